// File: rtl/kgp_risc_pkg.sv
// rtl/kgp_risc_pkg.sv - shared widths, fetch FSM states and opcodes for the kgp_risc core
package kgp_risc_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    // Major opcodes, shared with the decoder
    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - DEPTH-entry sync FIFO of {inst, pc} between fetch and decode
module fetch_buffer
    import kgp_risc_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [INST_W-1:0] push_inst_i,
    input  logic [ADDR_W-1:0] push_pc_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [CW-1:0]     count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [INST_W-1:0] head_inst_o,
    output logic [ADDR_W-1:0] head_pc_o
);

    logic [INST_W-1:0] inst_q [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign count_o     = cnt_q;
    assign empty_o     = (cnt_q == '0);
    assign full_o      = (cnt_q == CW'(DEPTH));
    assign head_inst_o = inst_q[rd_q];
    assign head_pc_o   = pc_q[rd_q];

    // Flush dominates both push and pop in the same cycle
    assign do_push = push_i & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = ptr_inc(wr_q);
            if (do_pop)  rd_d = ptr_inc(rd_q);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            if (do_push) begin
                inst_q[wr_q] <= push_inst_i;
                pc_q[wr_q]   <= push_pc_i;
            end
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: PC, imem request/response, redirect flush
module inst_fetch
    import kgp_risc_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CW-1:0]     out_q, out_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [ADDR_W-1:0] ipc_q [DEPTH];
    logic [PW-1:0]     ird_q, iwr_q;
    logic [CW-1:0]     buf_count;
    logic              buf_full, buf_empty;
    logic              credit, req_fire, rsp_keep, inst_pop;

    // In-flight requests plus buffered words may never exceed the FIFO depth
    assign credit = ({1'b0, out_q} + {1'b0, buf_count}) < DEPTH_C;

    assign imem_req_valid = ~rst & (state_q == FETCH) & ~halt & ~redirect_valid & credit;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign rsp_keep       = imem_rsp_valid & ~redirect_valid & (drop_q == '0);
    assign inst_valid     = ~buf_empty;
    assign inst_pop       = inst_valid & inst_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        out_d   = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
        if (req_fire) pc_d = pc_q + ADDR_W'(4);
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path
            pc_d   = word_align(redirect_pc);
            drop_d = out_d;
            if (drop_d != '0)  state_d = DRAIN;
            else if (halt)     state_d = HALT;
            else               state_d = FETCH;
        end else begin
            if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
            unique case (state_q)
                FETCH:   if (halt) state_d = HALT;
                DRAIN:   if (drop_d == '0) state_d = halt ? HALT : FETCH;
                HALT:    if (!halt) state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            out_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
        end
    end

    // PCs of in-flight requests, consumed in order by responses (stale ones included)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ird_q <= '0;
            iwr_q <= '0;
            for (int i = 0; i < DEPTH; i++) ipc_q[i] <= '0;
        end else begin
            if (req_fire) begin
                ipc_q[iwr_q] <= pc_q;
                iwr_q        <= (iwr_q == PW'(DEPTH - 1)) ? '0 : iwr_q + PW'(1);
            end
            if (imem_rsp_valid) begin
                ird_q <= (ird_q == PW'(DEPTH - 1)) ? '0 : ird_q + PW'(1);
            end
        end
    end

    fetch_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (rsp_keep),
        .push_inst_i (imem_rsp_data),
        .push_pc_i   (ipc_q[ird_q]),
        .pop_i       (inst_pop),
        .flush_i     (redirect_valid),
        .count_o     (buf_count),
        .full_o      (buf_full),
        .empty_o     (buf_empty),
        .head_inst_o (inst),
        .head_pc_o   (inst_pc)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (rsp_keep && !inst_pop) |-> !buf_full);

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;

    logic        req_valid2, req_ready2;
    logic [31:0] req_addr2;
    logic        rsp_valid2, redirect2, halt2, inst_valid2, inst_ready2;
    logic [31:0] rsp_data2, redirect_pc2, inst2, inst_pc2;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int lat    = 1;

    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] req_log[$];

    inst_fetch #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
    );

    inst_fetch #(.DEPTH(2), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid2), .imem_req_ready(req_ready2), .imem_req_addr(req_addr2),
        .imem_rsp_valid(rsp_valid2), .imem_rsp_data(rsp_data2),
        .redirect_valid(redirect2), .redirect_pc(redirect_pc2), .halt(halt2),
        .inst_valid(inst_valid2), .inst_ready(inst_ready2), .inst(inst2), .inst_pc(inst_pc2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Instruction memory: fixed latency, in order, cleared by rst
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            #2;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            if (rst) begin
                pend_addr.delete();
                pend_due.delete();
            end else begin
                if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(pend_addr[0]);
                    void'(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end
                if (imem_req_valid && imem_req_ready) begin
                    pend_addr.push_back(imem_req_addr);
                    pend_due.push_back(cyc + lat);
                    req_log.push_back(imem_req_addr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic do_reset(input int l);
        rst = 1'b1;
        halt = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        inst_ready = 1'b0;
        imem_req_ready = 1'b1;
        lat = l;
        repeat (2) @(negedge clk);
        req_log.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
        n_cmp++; if (inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst: got %h want 0", inst); end
        n_cmp++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL rst_inst_pc: got %h want 0", inst_pc); end
        n_cmp++; if (req_valid2 !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid2: got %b want 0", req_valid2); end
        @(negedge clk);
        req_log.delete();
        rst = 1'b0;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL rel_req_valid: got %b want 1", imem_req_valid); end
        n_cmp++; if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL rel_req_addr: got %h want 0", imem_req_addr); end
        n_cmp++; if (req_addr2 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL rel_req_addr2: got %h want fffffffc", req_addr2); end
        n_cmp++; if (req_valid2 !== 1'b1) begin n_fail++; $display("FAIL rel_req_valid2: got %b want 1", req_valid2); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        #1;
        n_cmp++; if (req_valid2 !== 1'b1) begin n_fail++; $display("FAIL wrap_valid: got %b want 1", req_valid2); end
        n_cmp++; if (req_addr2 !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got %h want 0", req_addr2); end
        @(negedge clk);
        #1;
        n_cmp++; if (req_valid2 !== 1'b0) begin n_fail++; $display("FAIL wrap_credit: got %b want 0", req_valid2); end
    endtask

    task automatic test_stream();
        int first_v;
        int npop;
        first_v = -1;
        npop = 0;
        do_reset(1);
        inst_ready = 1'b1;
        for (int c = 0; c < 40 && npop < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (inst_valid) begin
                if (first_v < 0) first_v = c;
                n_cmp++; if (inst_pc !== 32'(npop * 4)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h want %h", npop, inst_pc, 32'(npop * 4)); end
                n_cmp++; if (inst !== mem_word(32'(npop * 4))) begin n_fail++; $display("FAIL stream_inst[%0d]: got %h want %h", npop, inst, mem_word(32'(npop * 4))); end
                npop++;
            end
        end
        n_cmp++; if (first_v != 2) begin n_fail++; $display("FAIL stream_latency: got %0d want 2", first_v); end
        n_cmp++; if (npop != 6) begin n_fail++; $display("FAIL stream_count: got %0d want 6", npop); end
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (k >= req_log.size()) begin n_fail++; $display("FAIL stream_req[%0d]: missing want %h", k, 32'(k * 4)); end
            else if (req_log[k] !== 32'(k * 4)) begin n_fail++; $display("FAIL stream_req[%0d]: got %h want %h", k, req_log[k], 32'(k * 4)); end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1);
        inst_ready = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        n_cmp++; if (req_log.size() != 2) begin n_fail++; $display("FAIL bp_req_count: got %0d want 2", req_log.size()); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_valid: got %b want 0", imem_req_valid); end
        n_cmp++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head_pc: got %h want 0", inst_pc); end
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL bp_resume_valid: got %b want 1", imem_req_valid); end
        n_cmp++; if (imem_req_addr !== 32'h8) begin n_fail++; $display("FAIL bp_resume_addr: got %h want 8", imem_req_addr); end
        n_cmp++; if (inst_pc !== 32'h4) begin n_fail++; $display("FAIL bp_next_pc: got %h want 4", inst_pc); end
    endtask

    task automatic test_redirect();
        logic [31:0] first_pc;
        logic [31:0] first_inst;
        bit          seen;
        seen = 1'b0;
        first_pc = '0;
        first_inst = '0;
        do_reset(3);
        inst_ready = 1'b1;
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        #1;
        n_cmp++; if (req_log.size() != 2) begin n_fail++; $display("FAIL redir_outstanding: got %0d want 2", req_log.size()); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_req_blocked: got %b want 0", imem_req_valid); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_drain_req: got %b want 0", imem_req_valid); end
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (inst_valid) begin
                seen = 1'b1;
                first_pc = inst_pc;
                first_inst = inst;
            end
        end
        n_cmp++; if (!seen || first_pc !== 32'h100) begin n_fail++; $display("FAIL redir_first_pc: got %h (seen %b) want 100", first_pc, seen); end
        n_cmp++; if (first_inst !== mem_word(32'h100)) begin n_fail++; $display("FAIL redir_first_inst: got %h want %h", first_inst, mem_word(32'h100)); end
        n_cmp++;
        if (req_log.size() < 3) begin n_fail++; $display("FAIL redir_next_addr: missing want 100"); end
        else if (req_log[2] !== 32'h100) begin n_fail++; $display("FAIL redir_next_addr: got %h want 100", req_log[2]); end
    endtask

    task automatic test_redirect_same_cycle();
        logic [31:0] first_pc;
        bit          seen;
        seen = 1'b0;
        first_pc = '0;
        do_reset(1);
        inst_ready = 1'b1;
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        #1;
        n_cmp++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL same_head_valid: got %b want 1", inst_valid); end
        #2;
        n_cmp++; if (imem_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL same_rsp_present: got %b want 1", imem_rsp_valid); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL same_flushed: got %b want 0", inst_valid); end
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL same_req_valid: got %b want 1", imem_req_valid); end
        n_cmp++; if (imem_req_addr !== 32'h200) begin n_fail++; $display("FAIL same_req_addr: got %h want 200", imem_req_addr); end
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (inst_valid) begin
                seen = 1'b1;
                first_pc = inst_pc;
            end
        end
        n_cmp++; if (!seen || first_pc !== 32'h200) begin n_fail++; $display("FAIL same_first_pc: got %h (seen %b) want 200", first_pc, seen); end
    endtask

    task automatic test_halt();
        int  bad_req;
        bit  seen0;
        logic [31:0] word0;
        bad_req = 0;
        seen0 = 1'b0;
        word0 = '0;
        do_reset(3);
        inst_ready = 1'b1;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL halt_first_req: got %b want 1", imem_req_valid); end
        @(negedge clk);
        halt = 1'b1;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL halt_req_blocked: got %b want 0", imem_req_valid); end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            if (imem_req_valid) bad_req++;
            if (inst_valid && inst_pc == 32'h0) begin
                seen0 = 1'b1;
                word0 = inst;
            end
        end
        n_cmp++; if (bad_req != 0 || req_log.size() != 1) begin n_fail++; $display("FAIL halt_no_issue: got %0d valid cycles, %0d reqs want 0, 1", bad_req, req_log.size()); end
        n_cmp++; if (!seen0 || word0 !== mem_word(32'h0)) begin n_fail++; $display("FAIL halt_delivered: got %h (seen %b) want %h", word0, seen0, mem_word(32'h0)); end
        @(negedge clk);
        halt = 1'b0;
        for (int c = 0; c < 5 && req_log.size() < 2; c++) @(negedge clk);
        #1;
        n_cmp++;
        if (req_log.size() < 2) begin n_fail++; $display("FAIL halt_resume: no request want addr 4"); end
        else if (req_log[1] !== 32'h4) begin n_fail++; $display("FAIL halt_resume: got %h want 4", req_log[1]); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] first_pc;
        logic [31:0] first_inst;
        bit          seen;
        seen = 1'b0;
        first_pc = '0;
        first_inst = '0;
        do_reset(2);
        inst_ready = 1'b1;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_req_valid: got %b want 0", imem_req_valid); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL mid_inst_valid: got %b want 0", inst_valid); end
        n_cmp++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin n_fail++; $display("FAIL mid_outputs: got %h/%h want 0/0", inst, inst_pc); end
        repeat (2) @(negedge clk);
        req_log.delete();
        rst = 1'b0;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL mid_restart: got %b/%h want 1/0", imem_req_valid, imem_req_addr); end
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (inst_valid) begin
                seen = 1'b1;
                first_pc = inst_pc;
                first_inst = inst;
            end
        end
        n_cmp++; if (!seen || first_pc !== 32'h0 || first_inst !== mem_word(32'h0)) begin n_fail++; $display("FAIL mid_first: got %h/%h (seen %b) want 0/%h", first_pc, first_inst, seen, mem_word(32'h0)); end
    endtask

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        halt = 1'b0;
        inst_ready = 1'b0;
        req_ready2 = 1'b1;
        rsp_valid2 = 1'b0;
        rsp_data2 = '0;
        redirect2 = 1'b0;
        redirect_pc2 = '0;
        halt2 = 1'b0;
        inst_ready2 = 1'b0;

        test_reset();
        test_wrap();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_same_cycle();
        test_halt();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
